lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Load/store stage of the RV32E pipeline, directly upstream of the writeback unit.
- Accepts one instruction at a time from the execute stage over a valid/ready handshake.
- Performs any data-memory access on an AXI4-Lite master port, aligns and extends load data, then presents result, rd address and write-enable to writeback over valid/ready.
- Non-memory instructions pass through with fixed latency.

Parameters:
- RD_W, 4, register-address width (RV32E)
- ADDR_W, 32, data-memory address width

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_pre_valid  in  1  execute stage has an instruction
- o_pre_ready  out  1  stage can accept an instruction
- i_mem_ren  in  1  instruction is a load
- i_mem_wen  in  1  instruction is a store
- i_funct3  in  3  access size/sign (RV32 encoding)
- i_alu_res  in  32  effective address for load/store, result otherwise
- i_store_data  in  32  rs2 value for stores
- i_rd_addr  in  RD_W  destination register
- i_rd_wen  in  1  register write enable
- o_post_valid  out  1  result valid to writeback
- i_post_ready  in  1  writeback accepts result
- o_res  out  32  result (load data or i_alu_res)
- o_rd_addr  out  RD_W  registered rd
- o_rd_wen  out  1  registered write enable; forced 0 on fault
- o_fault  out  1  misaligned access or bus error, valid with o_post_valid
- m_araddr, m_arvalid, m_arready, m_rdata[32], m_rresp[2], m_rvalid, m_rready  AXI4-Lite read channels
- m_awaddr, m_awvalid, m_awready, m_wdata[32], m_wstrb[4], m_wvalid, m_wready, m_bresp[2], m_bvalid, m_bready  AXI4-Lite write channels

Behaviour:
- Reset values:
  - State IDLE.
  - o_pre_ready=1; o_post_valid=0; o_res=0; o_rd_addr=0; o_rd_wen=0; o_fault=0.
  - All m_*valid and m_*ready = 0.
- Handshakes:
  - o_pre_ready=1 only in IDLE; accept on i_pre_valid&&o_pre_ready.
  - All inputs are registered at accept; the upstream may change them afterwards.
- FSM:
  - IDLE -> ACCEPT decodes:
    - misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE, fault=1, no bus traffic.
    - load -> AR; store -> AW_W; otherwise -> DONE with o_res=i_alu_res.
  - AR: m_arvalid=1 with m_araddr=addr. Stay until m_arready -> R.
  - R: m_rready=1. On m_rvalid, capture extracted data -> DONE; m_rresp!=0 sets fault.
  - AW_W: m_awvalid and m_wvalid both asserted from state entry. Each drops independently on its own ready; the unit tracks which have completed. Both done -> B. Both readies in the same cycle are legal.
  - B: m_bready=1. On m_bvalid -> DONE; m_bresp!=0 sets fault.
  - DONE: o_post_valid=1, outputs stable. On i_post_ready -> IDLE.
- Latency: non-memory instruction reaches o_post_valid 1 cycle after accept; a load with zero-wait slave reaches it 3 cycles after accept.
- Load extraction, with byte offset o = addr[1:0]:
  - LB (000): sign-extend rdata[8o+7:8o].
  - LH (001): sign-extend 16 bits at 8o.
  - LW (010): full word.
  - LBU (100), LHU (101): zero-extend.
  - Other funct3 values: full word.
- Stores:
  - m_wstrb = (SB: 0001, SH: 0011, SW: 1111) << o.
  - m_wdata = store_data << 8o.
  - m_awaddr = full addr, unaligned low bits kept.
- Pass-through and fault:
  - o_rd_addr and o_rd_wen are registered copies.
  - o_rd_wen=0 whenever o_fault=1 or the instruction is a store.
- AXI rules:
  - A valid, once raised, is never dropped before its ready.
  - Address and data are held stable while valid is high.
- Reset mid-transaction: returns immediately to IDLE and drops every valid. The memory slave shares the reset, so no orphan response is expected.
- Simultaneous i_mem_ren and i_mem_wen: treated as a load.

Test Plan:
- ALU pass-through: accept {ren=0, wen=0, alu_res=0x1234, rd=5, rd_wen=1}, post_ready=1 -> o_post_valid one cycle later, o_res=0x1234, o_rd_addr=5, o_rd_wen=1, no AXI activity.
- LB sign-extend: addr 0x80000003, slave rdata 0x80FF_0000 -> o_res=0xFFFFFF80. LHU at 0x80000002, rdata 0xBEEF_0000 -> o_res=0x0000BEEF.
- SH store: addr 0x80000002, store_data 0x0000ABCD -> m_wstrb=1100, m_wdata=0xABCD0000. Slave gives wready 2 cycles before awready -> single B handshake, o_rd_wen=0.
- Misaligned LW at 0x80000001 -> no arvalid, o_fault=1, o_rd_wen=0.
- Backpressure: hold i_post_ready=0 for 5 cycles in DONE -> outputs stable, o_pre_ready=0, next instruction not accepted.
- Bus error and reset: rresp=2'b10 -> o_fault=1. Assert reset while in R -> m_rready=0 and o_pre_ready=1 immediately.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store stage of the RV32E pipeline: takes one instruction from execute,
// performs its AXI4-Lite data access if any, and hands the result to writeback.
module lsu_stage #(
  parameter int RD_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // execute-side handshake and instruction fields
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_alu_res,
  input  logic [31:0]       i_store_data,
  input  logic [RD_W-1:0]   i_rd_addr,
  input  logic              i_rd_wen,
  // writeback-side handshake and result
  output logic              o_post_valid,
  input  logic              i_post_ready,
  output logic [31:0]       o_res,
  output logic [RD_W-1:0]   o_rd_addr,
  output logic              o_rd_wen,
  output logic              o_fault,
  // AXI4-Lite read channels
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  // AXI4-Lite write channels
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         store_q;
  logic [2:0]          funct3_q;
  logic                aw_done, w_done;
  logic [31:0]         load_data;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [3:0]          strb_base;

  // Decode of the instruction being offered; funct3[1] marks a word-sized access.
  logic accept, is_load, is_store, misaligned;
  assign accept     = i_pre_valid && o_pre_ready;
  assign is_load    = i_mem_ren;
  assign is_store   = i_mem_wen && !i_mem_ren;
  assign misaligned = (i_mem_ren || i_mem_wen) &&
                      ((i_funct3[1:0] == 2'b01 && i_alu_res[0]) ||
                       (i_funct3[1]            && i_alu_res[1:0] != 2'b00));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: next-state defaults to the current state before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) begin
        if (misaligned)    state_next = S_DONE;
        else if (is_load)  state_next = S_AR;
        else if (is_store) state_next = S_AW_W;
        else               state_next = S_DONE;
      end
      S_AR:   if (m_arready) state_next = S_R;
      S_R:    if (m_rvalid)  state_next = S_DONE;
      S_AW_W: if ((aw_done || m_awready) && (w_done || m_wready)) state_next = S_B;
      S_B:    if (m_bvalid)  state_next = S_DONE;
      S_DONE: if (i_post_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so a reset drops them at once.
  assign o_pre_ready  = (state == S_IDLE);
  assign o_post_valid = (state == S_DONE);
  assign m_arvalid    = (state == S_AR);
  assign m_rready     = (state == S_R);
  assign m_awvalid    = (state == S_AW_W) && !aw_done;
  assign m_wvalid     = (state == S_AW_W) && !w_done;
  assign m_bready     = (state == S_B);

  assign m_araddr  = addr_q;
  assign m_awaddr  = addr_q;
  assign m_wdata   = store_q << {addr_q[1:0], 3'b000};
  assign strb_base = funct3_q[1] ? 4'b1111 : (funct3_q[0] ? 4'b0011 : 4'b0001);
  assign m_wstrb   = strb_base << addr_q[1:0];

  always_comb begin
    byte_sel  = m_rdata[7:0];
    half_sel  = addr_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    load_data = m_rdata;
    case (addr_q[1:0])
      2'd1:    byte_sel = m_rdata[15:8];
      2'd2:    byte_sel = m_rdata[23:16];
      2'd3:    byte_sel = m_rdata[31:24];
      default: byte_sel = m_rdata[7:0];
    endcase
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = m_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      store_q   <= '0;
      funct3_q  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      o_res     <= '0;
      o_rd_addr <= '0;
      o_rd_wen  <= 1'b0;
      o_fault   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          addr_q    <= i_alu_res[ADDR_W-1:0];
          store_q   <= i_store_data;
          funct3_q  <= i_funct3;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          o_res     <= i_alu_res;
          o_rd_addr <= i_rd_addr;
          o_rd_wen  <= i_rd_wen && !is_store && !misaligned;
          o_fault   <= misaligned;
        end
        S_R: if (m_rvalid) begin
          o_res <= load_data;
          if (m_rresp != 2'b00) begin
            o_fault  <= 1'b1;
            o_rd_wen <= 1'b0;
          end
        end
        S_AW_W: begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
        S_B: if (m_bvalid && m_bresp != 2'b00) begin
          o_fault  <= 1'b1;
          o_rd_wen <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: a vector table for single transactions plus
// hand-written sequences for write-channel skew, backpressure and mid-access reset.
module tb_lsu_stage;
  localparam int RD_W   = 4;
  localparam int ADDR_W = 32;

  logic              clock, reset;
  logic              i_pre_valid, o_pre_ready, i_mem_ren, i_mem_wen;
  logic [2:0]        i_funct3;
  logic [31:0]       i_alu_res, i_store_data;
  logic [RD_W-1:0]   i_rd_addr;
  logic              i_rd_wen;
  logic              o_post_valid, i_post_ready;
  logic [31:0]       o_res;
  logic [RD_W-1:0]   o_rd_addr;
  logic              o_rd_wen, o_fault;
  logic [ADDR_W-1:0] m_araddr, m_awaddr;
  logic              m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]       m_rdata, m_wdata;
  logic [1:0]        m_rresp, m_bresp;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]        m_wstrb;

  lsu_stage #(.RD_W(RD_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_funct3(i_funct3),
    .i_alu_res(i_alu_res), .i_store_data(i_store_data),
    .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .o_res(o_res), .o_rd_addr(o_rd_addr), .o_rd_wen(o_rd_wen), .o_fault(o_fault),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  logic        ar_rdy = 1'b1, aw_rdy = 1'b1, w_rdy = 1'b1, r_en = 1'b1;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;
  logic        aw_g, w_g;
  wire ar_hs = m_arvalid && m_arready;
  wire aw_hs = m_awvalid && m_awready;
  wire w_hs  = m_wvalid && m_wready;
  wire b_hs  = m_bvalid && m_bready;

  assign m_arready = ar_rdy;
  assign m_awready = aw_rdy;
  assign m_wready  = w_rdy;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
      m_bvalid <= 1'b0; m_bresp <= '0; aw_g <= 1'b0; w_g <= 1'b0;
    end else begin
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      else if (ar_hs && r_en) begin
        m_rvalid <= 1'b1; m_rdata <= s_rdata; m_rresp <= s_rresp;
      end
      if (b_hs) m_bvalid <= 1'b0;
      else if ((aw_g || aw_hs) && (w_g || w_hs) && !m_bvalid) begin
        m_bvalid <= 1'b1; m_bresp <= s_bresp; aw_g <= 1'b0; w_g <= 1'b0;
      end else begin
        if (aw_hs) aw_g <= 1'b1;
        if (w_hs)  w_g  <= 1'b1;
      end
    end
  end

  // ---------------- bus monitor: handshake counts and stability ----------------
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, viol = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        pend_ar, pend_aw, pend_w;
  logic [31:0] prev_araddr, prev_awaddr, prev_wdata;
  logic [3:0]  prev_wstrb;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_ar <= 1'b0; pend_aw <= 1'b0; pend_w <= 1'b0;
      prev_araddr <= '0; prev_awaddr <= '0; prev_wdata <= '0; prev_wstrb <= '0;
    end else begin
      if (ar_hs) n_ar <= n_ar + 1;
      if (aw_hs) begin n_aw <= n_aw + 1; cap_awaddr <= m_awaddr; end
      if (w_hs)  begin n_w <= n_w + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
      if (b_hs)  n_b <= n_b + 1;
      if ((pend_ar && (!m_arvalid || m_araddr != prev_araddr)) ||
          (pend_aw && (!m_awvalid || m_awaddr != prev_awaddr)) ||
          (pend_w  && (!m_wvalid || m_wdata != prev_wdata || m_wstrb != prev_wstrb)))
        viol <= viol + 1;
      pend_ar <= m_arvalid && !m_arready; prev_araddr <= m_araddr;
      pend_aw <= m_awvalid && !m_awready; prev_awaddr <= m_awaddr;
      pend_w  <= m_wvalid && !m_wready;   prev_wdata  <= m_wdata; prev_wstrb <= m_wstrb;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        ren, wen;
    logic [2:0]  f3;
    logic [31:0] alu, sdata;
    logic [3:0]  rd;
    logic        rdwen;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        chk_res;
    logic [31:0] e_res;
    logic        e_rdwen, e_fault;
    int          e_lat, e_ar, e_wr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[16];

  task automatic drive_instr(input logic ren, input logic wen, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] sdata,
                             input logic [3:0] rd, input logic rdwen);
    i_mem_ren = ren; i_mem_wen = wen; i_funct3 = f3; i_alu_res = alu;
    i_store_data = sdata; i_rd_addr = rd; i_rd_wen = rdwen; i_pre_valid = 1'b1;
  endtask

  task automatic scramble();
    i_pre_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_funct3 = 3'b111;
    i_alu_res = ~i_alu_res; i_store_data = ~i_store_data;
    i_rd_addr = ~i_rd_addr; i_rd_wen = ~i_rd_wen;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ar0, aw0, w0, b0, lat;
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b;
    @(negedge clock);
    check($sformatf("v%0d pre_ready", idx), o_pre_ready, 1);
    s_rdata = v.rdata; s_rresp = v.rresp; s_bresp = v.bresp;
    drive_instr(v.ren, v.wen, v.f3, v.alu, v.sdata, v.rd, v.rdwen);
    @(negedge clock);
    scramble();
    lat = 1;
    while (!o_post_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check($sformatf("v%0d latency", idx), lat, v.e_lat);
    if (v.chk_res) check($sformatf("v%0d res", idx), o_res, v.e_res);
    check($sformatf("v%0d rd_addr", idx), o_rd_addr, v.rd);
    check($sformatf("v%0d rd_wen", idx), o_rd_wen, v.e_rdwen);
    check($sformatf("v%0d fault", idx), o_fault, v.e_fault);
    check($sformatf("v%0d ar count", idx), n_ar - ar0, v.e_ar);
    check($sformatf("v%0d aw count", idx), n_aw - aw0, v.e_wr);
    check($sformatf("v%0d w count", idx), n_w - w0, v.e_wr);
    check($sformatf("v%0d b count", idx), n_b - b0, v.e_wr);
    if (v.e_wr != 0) begin
      check($sformatf("v%0d awaddr", idx), cap_awaddr, v.alu);
      check($sformatf("v%0d wstrb", idx), cap_wstrb, v.e_wstrb);
      check($sformatf("v%0d wdata", idx), cap_wdata, v.e_wdata);
    end
  endtask

  initial begin
    int ar0, aw0, w0, b0, n;
    //          ren wen f3      alu           sdata         rd    rdwen rdata         rr    br    chk e_res         rdw flt lat ar wr strb  wdata
    vecs[0]  = '{0, 0, 3'b000, 32'h00001234, 32'h0,        4'd5,  1, 32'h0,        2'd0, 2'd0, 1, 32'h00001234, 1, 0, 1, 0, 0, 4'h0, 32'h0};
    vecs[1]  = '{1, 0, 3'b000, 32'h80000003, 32'h0,        4'd3,  1, 32'h80FF0000, 2'd0, 2'd0, 1, 32'hFFFFFF80, 1, 0, 3, 1, 0, 4'h0, 32'h0};
    vecs[2]  = '{1, 0, 3'b101, 32'h80000002, 32'h0,        4'd4,  1, 32'hBEEF0000, 2'd0, 2'd0, 1, 32'h0000BEEF, 1, 0, 3, 1, 0, 4'h0, 32'h0};
    vecs[3]  = '{1, 0, 3'b001, 32'h80000002, 32'h0,        4'd6,  1, 32'hBEEF0000, 2'd0, 2'd0, 1, 32'hFFFFBEEF, 1, 0, 3, 1, 0, 4'h0, 32'h0};
    vecs[4]  = '{1, 0, 3'b100, 32'h80000001, 32'h0,        4'd7,  1, 32'h0000A500, 2'd0, 2'd0, 1, 32'h000000A5, 1, 0, 3, 1, 0, 4'h0, 32'h0};
    vecs[5]  = '{1, 0, 3'b010, 32'h80000004, 32'h0,        4'd8,  1, 32'hDEADBEEF, 2'd0, 2'd0, 1, 32'hDEADBEEF, 1, 0, 3, 1, 0, 4'h0, 32'h0};
    vecs[6]  = '{1, 0, 3'b010, 32'h80000001, 32'h0,        4'd9,  1, 32'h0,        2'd0, 2'd0, 0, 32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0};
    vecs[7]  = '{1, 0, 3'b001, 32'h80000003, 32'h0,        4'd10, 1, 32'h0,        2'd0, 2'd0, 0, 32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0};
    vecs[8]  = '{1, 0, 3'b010, 32'h80000008, 32'h0,        4'd11, 1, 32'h12345678, 2'd2, 2'd0, 0, 32'h0,        0, 1, 3, 1, 0, 4'h0, 32'h0};
    vecs[9]  = '{0, 1, 3'b010, 32'h80000010, 32'h11223344, 4'd9,  1, 32'h0,        2'd0, 2'd0, 0, 32'h0,        0, 0, 3, 0, 1, 4'hF, 32'h11223344};
    vecs[10] = '{0, 1, 3'b000, 32'h80000013, 32'h000000AB, 4'd2,  1, 32'h0,        2'd0, 2'd0, 0, 32'h0,        0, 0, 3, 0, 1, 4'h8, 32'hAB000000};
    vecs[11] = '{0, 1, 3'b000, 32'h80000020, 32'h0000005A, 4'd1,  1, 32'h0,        2'd0, 2'd3, 0, 32'h0,        0, 1, 3, 0, 1, 4'h1, 32'h0000005A};
    vecs[12] = '{1, 1, 3'b010, 32'h80000030, 32'hFFFFFFFF, 4'd12, 1, 32'hCAFEF00D, 2'd0, 2'd0, 1, 32'hCAFEF00D, 1, 0, 3, 1, 0, 4'h0, 32'h0};
    vecs[13] = '{0, 0, 3'b010, 32'hFFFFFFFF, 32'h0,        4'd15, 0, 32'h0,        2'd0, 2'd0, 1, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 4'h0, 32'h0};
    vecs[14] = '{1, 0, 3'b011, 32'h80000040, 32'h0,        4'd13, 1, 32'h01234567, 2'd0, 2'd0, 1, 32'h01234567, 1, 0, 3, 1, 0, 4'h0, 32'h0};
    vecs[15] = '{1, 0, 3'b000, 32'h80000000, 32'h0,        4'd14, 1, 32'h0000007F, 2'd0, 2'd0, 1, 32'h0000007F, 1, 0, 3, 1, 0, 4'h0, 32'h0};

    reset = 1'b1; i_pre_valid = 1'b0; i_post_ready = 1'b1;
    i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_funct3 = '0; i_alu_res = '0;
    i_store_data = '0; i_rd_addr = '0; i_rd_wen = 1'b0;
    repeat (2) @(negedge clock);
    check("reset pre_ready", o_pre_ready, 1);
    check("reset post_valid", o_post_valid, 0);
    check("reset res", o_res, 0);
    check("reset rd_addr/rd_wen/fault", {o_rd_addr, o_rd_wen, o_fault}, 0);
    check("reset axi valids/readies", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // SH with the write data accepted two cycles before the address.
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b;
    aw_rdy = 1'b0; w_rdy = 1'b1; s_bresp = 2'd0;
    @(negedge clock);
    drive_instr(1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 4'd3, 1'b1);
    @(negedge clock);
    scramble();
    check("sh both valids at entry", {m_awvalid, m_wvalid}, 2'b11);
    @(negedge clock);
    check("sh after wready", {m_awvalid, m_wvalid}, 2'b10);
    @(negedge clock);
    check("sh aw still waiting", {m_awvalid, m_wvalid, m_bready}, 3'b100);
    aw_rdy = 1'b1;
    n = 0;
    while (!o_post_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("sh reached done", o_post_valid, 1);
    check("sh handshakes ar/aw/w/b", {n_ar - ar0, n_aw - aw0, n_w - w0, n_b - b0}, 128'h0_00000001_00000001_00000001);
    check("sh wstrb", cap_wstrb, 4'b1100);
    check("sh wdata", cap_wdata, 32'hABCD0000);
    check("sh awaddr", cap_awaddr, 32'h80000002);
    check("sh rd_wen/fault", {o_rd_wen, o_fault}, 2'b00);

    // Backpressure: result held in DONE while a second instruction waits upstream.
    @(negedge clock);
    i_post_ready = 1'b0;
    drive_instr(1'b0, 1'b0, 3'b000, 32'hA5A5A5A5, 32'h0, 4'd10, 1'b1);
    @(negedge clock);
    drive_instr(1'b0, 1'b0, 3'b000, 32'h00005555, 32'h0, 4'd11, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp c%0d valid/ready", c), {o_post_valid, o_pre_ready}, 2'b10);
      check($sformatf("bp c%0d res", c), o_res, 32'hA5A5A5A5);
      check($sformatf("bp c%0d rd", c), {o_rd_addr, o_rd_wen}, {4'd10, 1'b1});
      @(negedge clock);
    end
    i_post_ready = 1'b1;
    @(negedge clock);
    check("bp released idle", {o_post_valid, o_pre_ready}, 2'b01);
    @(negedge clock);
    scramble();
    check("bp second valid", o_post_valid, 1);
    check("bp second res", o_res, 32'h00005555);
    check("bp second rd", o_rd_addr, 4'd11);

    // Reset while waiting on the read data channel.
    @(negedge clock);
    r_en = 1'b0;
    drive_instr(1'b1, 1'b0, 3'b010, 32'h80000050, 32'h0, 4'd4, 1'b1);
    @(negedge clock);
    scramble();
    n = 0;
    while (!m_rready && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("rst-in-R reached R", m_rready, 1);
    #2 reset = 1'b1;
    #1;
    check("rst-in-R rready dropped", m_rready, 0);
    check("rst-in-R pre_ready", o_pre_ready, 1);
    check("rst-in-R other valids", {m_arvalid, m_awvalid, m_wvalid, o_post_valid}, 0);
    @(negedge clock);
    reset = 1'b0; r_en = 1'b1;
    run_vec(vecs[0], 100);

    check("axi valid/stability violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
